frq_divider_multi: RTL and testbench

//  Multi-channel, select-controlled clock divider: successor to the single-channel 5-bit-select divider.

---
 rtl/frq_divider_multi.sv | 97 +++++++++
 tb/tb_frq_divider_multi.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/frq_divider_multi.sv
// rtl/frq_divider_multi.sv - multi-channel select-controlled clock divider, glitch-free boundary updates
module frq_divider_multi #(
    parameter int N_CH       = 2,
    parameter int SEL_W      = 5,
    parameter int HALF_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [N_CH*SEL_W-1:0]   sel,
    input  logic [N_CH-1:0]         pulse_mode,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         period_tick,
    output logic [N_CH-1:0]         active
);
    localparam int CNT_W = SEL_W + HALF_SHIFT + 1;

    typedef enum logic {S_OFF, S_RUN} state_t;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t             state_q, state_d;
        logic [SEL_W-1:0]   sel_q, sel_d, sel_in;
        logic               mode_q, mode_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [CNT_W-1:0]   half_q, last_q, half_d;
        logic               clk_q, clk_d, tick_q, tick_d, act_q, act_d;
        logic               start;

        assign sel_in = sel[c*SEL_W +: SEL_W];
        assign start  = en && (sel_in != '0);
        assign half_q = CNT_W'(sel_q) << HALF_SHIFT;
        assign last_q = (half_q << 1) - CNT_W'(1);
        assign half_d = CNT_W'(sel_d) << HALF_SHIFT;

        always_comb begin
            state_d = state_q;
            sel_d   = sel_q;
            mode_d  = mode_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_OFF: begin
                    if (start) begin
                        state_d = S_RUN;
                        sel_d   = sel_in;
                        mode_d  = pulse_mode[c];
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    // Inputs are only honoured at the end of a full period
                    if (cnt_q == last_q) begin
                        cnt_d = '0;
                        if (start) begin
                            sel_d  = sel_in;
                            mode_d = pulse_mode[c];
                        end else begin
                            state_d = S_OFF;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase

            // Outputs are registered from the next-state view so they line up with cnt
            act_d  = (state_d == S_RUN);
            tick_d = act_d && (cnt_d == '0);
            clk_d  = act_d && (mode_d ? (cnt_d == '0) : (cnt_d < half_d));
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_OFF;
                sel_q   <= '0;
                mode_q  <= 1'b0;
                cnt_q   <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                act_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                sel_q   <= sel_d;
                mode_q  <= mode_d;
                cnt_q   <= cnt_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
                act_q   <= act_d;
            end
        end

        assign clk_out[c]     = clk_q;
        assign period_tick[c] = tick_q;
        assign active[c]      = act_q;
    end

endmodule

// File: tb/tb_frq_divider_multi.sv
// tb/tb_frq_divider_multi.sv - self-checking bench for frq_divider_multi
module tb_frq_divider_multi;
    localparam int N_CH  = 2;
    localparam int SEL_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
    logic [9:0]       sel = '0;
    logic [1:0]       pm = '0;
    logic [1:0]       clk_out, tick, act;
    logic             en_b = 1'b0;
    logic [9:0]       sel_b = '0;
    logic [1:0]       pm_b = '0;
    logic [1:0]       clk_out_b, tick_b, act_b;

    int chk_cnt = 0;
    int pass_cnt = 0;

    frq_divider_multi #(.N_CH(N_CH), .SEL_W(SEL_W), .HALF_SHIFT(0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .pulse_mode(pm),
        .clk_out(clk_out), .period_tick(tick), .active(act)
    );

    frq_divider_multi #(.N_CH(N_CH), .SEL_W(SEL_W), .HALF_SHIFT(2)) dut_hs (
        .clk(clk), .reset_n(reset_n), .en(en_b), .sel(sel_b), .pulse_mode(pm_b),
        .clk_out(clk_out_b), .period_tick(tick_b), .active(act_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        en = 1'b0; sel = '0; pm = '0;
        en_b = 1'b0; sel_b = '0; pm_b = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_len(input logic val, output int n);
        n = 0;
        while (clk_out[0] === val && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [4:0] s;
        logic       mode;
        int         exp_high;
        int         exp_low;
    } vec_t;
    vec_t vecs[6];

    // Reference model: position within the current period, 0 length means off
    int m_pos[2], m_len[2];
    logic m_mode[2];

    function automatic logic [5:0] model_out();
        logic [1:0] c_o, t_o, a_o;
        for (int c = 0; c < 2; c++) begin
            a_o[c] = (m_len[c] != 0);
            t_o[c] = a_o[c] && m_pos[c] == 0;
            c_o[c] = a_o[c] && (m_mode[c] ? (m_pos[c] == 0) : (m_pos[c] < m_len[c] / 2));
        end
        return {c_o, t_o, a_o};
    endfunction

    initial begin
        int h, l;
        logic [18:0] wave, ewave;
        logic [7:0] w_clk, w_act, e_clk, e_act;

        vecs[0] = '{5'd3,  1'b0, 3,  3};
        vecs[1] = '{5'd1,  1'b0, 1,  1};
        vecs[2] = '{5'd1,  1'b1, 1,  1};
        vecs[3] = '{5'd4,  1'b1, 1,  7};
        vecs[4] = '{5'd31, 1'b0, 31, 31};
        vecs[5] = '{5'd5,  1'b1, 1,  9};

        do_reset();
        chk("reset_state", {26'd0, clk_out, tick, act}, 32'd0);

        // Asynchronous reset in the middle of a high phase
        en = 1'b1; sel = 10'd5;
        @(negedge clk);
        chk("reset_pre_active", {31'd0, act[0]}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("reset_async", {26'd0, clk_out, tick, act}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_reset();
            en = 1'b1; sel = {5'd0, vecs[i].s}; pm = {1'b0, vecs[i].mode};
            @(negedge clk);
            chk($sformatf("vec%0d_tick", i), {30'd0, tick[0], act[0]}, 32'd3);
            run_len(1'b1, h);
            run_len(1'b0, l);
            chk($sformatf("vec%0d_high", i), h, vecs[i].exp_high);
            chk($sformatf("vec%0d_low", i), l, vecs[i].exp_low);
        end

        // Select change mid-period only takes effect at the boundary
        do_reset();
        en = 1'b1; sel = 10'd3;
        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            wave[i] = clk_out[0];
            ewave[i] = (i < 3) || (i >= 6 && i < 12) || (i >= 18);
            if (i == 1) sel = 10'd6;
            @(negedge clk);
        end
        chk("switch_wave", {13'd0, wave}, {13'd0, ewave});

        // Disable mid-period completes the period before stopping
        do_reset();
        en = 1'b1; sel = 10'd3;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            w_clk[i] = clk_out[0];
            w_act[i] = act[0];
            e_clk[i] = (i < 3);
            e_act[i] = (i < 6);
            if (i == 2) en = 1'b0;
            @(negedge clk);
        end
        chk("stop_clk", {24'd0, w_clk}, {24'd0, e_clk});
        chk("stop_active", {24'd0, w_act}, {24'd0, e_act});
        en = 1'b1;
        @(negedge clk);
        chk("restart", {30'd0, clk_out[0], act[0]}, 32'd3);

        // Two channels, HALF_SHIFT=2, started together
        do_reset();
        en_b = 1'b1; sel_b = {5'd1, 5'd1}; pm_b = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            logic e;
            e = (i % 8) < 4;
            chk($sformatf("multi_%0d", i), {28'd0, clk_out_b, tick_b},
                {28'd0, e, e, (i % 8) == 0, (i % 8) == 0});
            @(negedge clk);
        end

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 2; c++) begin
            m_pos[c] = 0; m_len[c] = 0; m_mode[c] = 1'b0;
        end
        en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk($sformatf("rand_%0d", cyc), {26'd0, clk_out, tick, act}, {26'd0, model_out()});
            if ($urandom_range(0, 7) == 0) begin
                int c;
                c = $urandom_range(0, 1);
                sel[c*5 +: 5] = 5'($urandom_range(0, 6));
                pm[c] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 39) == 0) en = ~en;
            @(posedge clk);
            for (int c = 0; c < 2; c++) begin
                if (m_len[c] != 0 && m_pos[c] < m_len[c] - 1) begin
                    m_pos[c]++;
                end else if (en && sel[c*5 +: 5] != 0) begin
                    m_len[c] = 2 * int'(sel[c*5 +: 5]);
                    m_mode[c] = pm[c];
                    m_pos[c] = 0;
                end else begin
                    m_len[c] = 0;
                    m_pos[c] = 0;
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
